countdown_timer_ctrl: RTL

- Control stage directly upstream of a pair of cascaded decimal_down_counter instances: ones digit and tens digit.
- Generates the one-second count tick and the load strobe with BCD preset data for those counters.
- Consumes their tc outputs to detect expiry at 00.
- Runs a start/pause/stop/expire state machine for the game countdown shown on the VGA display.

---
 rtl/countdown_timer_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/countdown_timer_ctrl.sv
// Control stage for a two-digit BCD countdown built from cascaded down counters.
// Issues the per-second tick and the preset load, and tracks start/pause/stop/expiry.
module countdown_timer_ctrl #(
  parameter  int TICK_DIV = 31_500_000,
  localparam int DIV_W    = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_p,
  input  logic       pause_p,
  input  logic       stop_p,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  input  logic       tc_tens,
  input  logic       tc_ones,
  output logic       loadN,
  output logic [3:0] datain_tens,
  output logic [3:0] datain_ones,
  output logic       ena,
  output logic       ena_cnt_ones,
  output logic       ena_cnt_tens,
  output logic       running,
  output logic       paused,
  output logic       expired_p
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  state_t           r_state;
  state_t           w_next;
  logic [DIV_W-1:0] r_div_cnt;
  logic [3:0]       r_datain_tens;
  logic [3:0]       r_datain_ones;
  logic             r_loadn;
  logic             r_expired;
  logic             w_tick;
  logic             w_expire;
  logic             w_start_acc;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    bcd_clamp = (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign w_tick      = (r_state == S_RUN) && (r_div_cnt == DIV_MAX);
  // A tick landing on 00 would wrap the counters, so expiry waits for a tick-free cycle.
  assign w_expire    = tc_ones & tc_tens & ~w_tick;
  assign w_start_acc = start_p && !stop_p && (r_state != S_LOAD);

  // Next-state decode: stop beats start, start beats pause.
  always_comb begin
    w_next = r_state;
    if (stop_p) begin
      w_next = S_IDLE;
    end else if (start_p && (r_state != S_LOAD)) begin
      w_next = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD: w_next = S_RUN;
        S_RUN: begin
          if (pause_p) begin
            w_next = S_PAUSED;
          end else if (w_expire) begin
            w_next = S_DONE;
          end else begin
            w_next = S_RUN;
          end
        end
        S_PAUSED: begin
          if (pause_p) begin
            w_next = S_RUN;
          end else begin
            w_next = S_PAUSED;
          end
        end
        default: w_next = r_state;
      endcase
    end
  end

  // State register and registered strobes/load data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_loadn       <= 1'b1;
      r_expired     <= 1'b0;
      r_datain_tens <= 4'd0;
      r_datain_ones <= 4'd0;
    end else begin
      r_state   <= w_next;
      r_loadn   <= (w_next != S_LOAD);
      r_expired <= (r_state == S_RUN) && (w_next == S_DONE);
      if (w_start_acc) begin
        r_datain_tens <= bcd_clamp(preset_tens);
        r_datain_ones <= bcd_clamp(preset_ones);
      end
    end
  end

  // Tick prescaler: cleared by LOAD, runs in RUN, frozen everywhere else.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= {DIV_W{1'b0}};
    end else if (r_state == S_LOAD) begin
      r_div_cnt <= {DIV_W{1'b0}};
    end else if (r_state == S_RUN) begin
      r_div_cnt <= (r_div_cnt == DIV_MAX) ? {DIV_W{1'b0}} : r_div_cnt + DIV_W'(1);
    end
  end

  assign loadN        = r_loadn;
  assign datain_tens  = r_datain_tens;
  assign datain_ones  = r_datain_ones;
  assign expired_p    = r_expired;
  assign ena          = w_tick;
  assign ena_cnt_ones = (r_state == S_RUN);
  assign ena_cnt_tens = (r_state == S_RUN) & tc_ones;
  assign running      = (r_state == S_RUN);
  assign paused       = (r_state == S_PAUSED);

endmodule
